// File: rtl/apb_decoder_pkg.sv
// Shared types and constants for the APB address decoder/bridge.
// Base values are the paddr[31:24] windows of the register blocks behind the bridge.
package apb_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_dec_state_t;

   localparam int APB_DEC_NUM_DST = 2;
   localparam int APB_DEC_SEL_W   = 8;
   localparam int APB_DEC_AW      = 32;
   localparam int APB_DEC_DW      = 32;

   localparam logic [APB_DEC_SEL_W-1:0] BLOCKA_BASE = 8'h01;
   localparam logic [APB_DEC_SEL_W-1:0] BLOCKB_BASE = 8'h02;

endpackage

// File: rtl/apb_if.sv
// Plain APB bus bundle; src drives the request, dst returns the completion.
interface apb_if;
   import apb_decoder_pkg::*;

   logic [APB_DEC_AW-1:0] paddr;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [APB_DEC_DW-1:0] pwdata;
   logic [APB_DEC_DW-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport src (output paddr, psel, penable, pwrite, pwdata,
                input  prdata, pready, pslverr);
   modport dst (input  paddr, psel, penable, pwrite, pwdata,
                output prdata, pready, pslverr);
endinterface

// File: rtl/apb_dec_timeout.sv
// Access-phase watchdog: counts enabled cycles from a clear and flags the last
// permitted cycle so the bridge can abort on the following edge.
module apb_dec_timeout #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expire = (cnt_q == CNT_TC);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_decoder.sv
// APB bridge: decodes paddr[SEL_MSB:SEL_LSB] to one of NUM_DST completers and
// replays the transfer with registered setup; unmapped or hung accesses get pslverr.
//
// state  | meaning
// IDLE   | waiting for upstream psel; captures and decodes the request
// SETUP  | selected downstream psel=1, penable=0
// ACCESS | selected downstream psel=1, penable=1, watchdog running
// RESP   | upstream pready=1 for one cycle with registered prdata/pslverr
module apb_decoder
   import apb_decoder_pkg::*;
#(
   parameter int NUM_DST        = APB_DEC_NUM_DST,
   parameter int SEL_MSB        = 31,
   parameter int SEL_LSB        = 24,
   // element [0] is the rightmost entry: port 0 decodes BLOCKA_BASE
   parameter logic [NUM_DST-1:0][SEL_MSB-SEL_LSB:0] DST_BASE = {BLOCKB_BASE, BLOCKA_BASE},
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   apb_if.dst          apbUp,
   apb_if.src          apbDn [NUM_DST],
   output logic [15:0] errCount,
   output logic        toSticky
);

   localparam int IDX_W = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;

   apb_dec_state_t state_q, state_d;

   logic [IDX_W-1:0]      port_q, port_d;
   logic [APB_DEC_AW-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [APB_DEC_DW-1:0] pwdata_q, pwdata_d;
   logic [NUM_DST-1:0]    dn_psel_q, dn_psel_d;
   logic [NUM_DST-1:0]    dn_penable_q, dn_penable_d;
   logic                  up_pready_q, up_pready_d;
   logic [APB_DEC_DW-1:0] up_prdata_q, up_prdata_d;
   logic                  up_pslverr_q, up_pslverr_d;
   logic [15:0]           err_cnt_q, err_cnt_d;
   logic                  to_sticky_q, to_sticky_d;

   logic                                dn_pready;
   logic [NUM_DST-1:0]                  dn_pready_vec;
   logic [NUM_DST-1:0]                  dn_pslverr_vec;
   logic [NUM_DST-1:0][APB_DEC_DW-1:0]  dn_prdata_vec;

   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic             tmo_clr, tmo_en, tmo_expire;
   logic             unused_up_penable;

   // Upstream penable carries no information the FSM needs.
   assign unused_up_penable = apbUp.penable;

   for (genvar g = 0; g < NUM_DST; g++) begin : g_dn
      assign apbDn[g].psel    = dn_psel_q[g];
      assign apbDn[g].penable = dn_penable_q[g];
      assign apbDn[g].paddr   = paddr_q;
      assign apbDn[g].pwrite  = pwrite_q;
      assign apbDn[g].pwdata  = pwdata_q;
      assign dn_pready_vec[g]  = apbDn[g].pready;
      assign dn_pslverr_vec[g] = apbDn[g].pslverr;
      assign dn_prdata_vec[g]  = apbDn[g].prdata;
   end

   assign dn_pready = dn_pready_vec[port_q];

   assign apbUp.pready  = up_pready_q;
   assign apbUp.prdata  = up_prdata_q;
   assign apbUp.pslverr = up_pslverr_q;
   assign errCount      = err_cnt_q;
   assign toSticky      = to_sticky_q;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NUM_DST; i++) begin
         if (apbUp.paddr[SEL_MSB:SEL_LSB] == DST_BASE[i]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   apb_dec_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expire (tmo_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (apbUp.psel) state_d = hit ? SETUP : RESP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (dn_pready || tmo_expire) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      port_d       = port_q;
      paddr_d      = paddr_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      dn_psel_d    = dn_psel_q;
      dn_penable_d = dn_penable_q;
      up_pready_d  = 1'b0;
      up_prdata_d  = up_prdata_q;
      up_pslverr_d = up_pslverr_q;
      err_cnt_d    = err_cnt_q;
      to_sticky_d  = to_sticky_q;
      tmo_clr      = 1'b0;
      tmo_en       = 1'b0;

      case (state_q)
         IDLE: begin
            if (apbUp.psel) begin
               paddr_d  = apbUp.paddr;
               pwrite_d = apbUp.pwrite;
               pwdata_d = apbUp.pwdata;
               if (hit) begin
                  port_d    = hit_idx;
                  dn_psel_d = NUM_DST'(1) << hit_idx;
                  tmo_clr   = 1'b1;
               end else begin
                  up_prdata_d  = '0;
                  up_pslverr_d = 1'b1;
                  up_pready_d  = 1'b1;
               end
            end
         end
         SETUP: begin
            dn_penable_d = dn_psel_q;
         end
         ACCESS: begin
            tmo_en = 1'b1;
            // a completion on the expiry cycle still counts as a normal response
            if (dn_pready) begin
               up_prdata_d  = dn_prdata_vec[port_q];
               up_pslverr_d = dn_pslverr_vec[port_q];
               up_pready_d  = 1'b1;
               dn_psel_d    = '0;
               dn_penable_d = '0;
            end else if (tmo_expire) begin
               up_prdata_d  = '0;
               up_pslverr_d = 1'b1;
               up_pready_d  = 1'b1;
               to_sticky_d  = 1'b1;
               dn_psel_d    = '0;
               dn_penable_d = '0;
            end
         end
         default: begin
         end
      endcase

      if (up_pready_d && up_pslverr_d && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         port_q       <= '0;
         paddr_q      <= '0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= '0;
         dn_psel_q    <= '0;
         dn_penable_q <= '0;
         up_pready_q  <= 1'b0;
         up_prdata_q  <= '0;
         up_pslverr_q <= 1'b0;
         err_cnt_q    <= '0;
         to_sticky_q  <= 1'b0;
      end else begin
         port_q       <= port_d;
         paddr_q      <= paddr_d;
         pwrite_q     <= pwrite_d;
         pwdata_q     <= pwdata_d;
         dn_psel_q    <= dn_psel_d;
         dn_penable_q <= dn_penable_d;
         up_pready_q  <= up_pready_d;
         up_prdata_q  <= up_prdata_d;
         up_pslverr_q <= up_pslverr_d;
         err_cnt_q    <= err_cnt_d;
         to_sticky_q  <= to_sticky_d;
      end
   end

endmodule

// File: tb/tb_apb_decoder.sv
// Directed bench for apb_decoder: vector table of single transfers plus
// hand sequences for timeout, back-to-back, reset-in-flight and saturation.
module tb_apb_decoder;

   logic clk;
   logic rst;
   logic [15:0] err_count;
   logic        to_sticky;

   logic [1:0]  cpl_hang;
   int          cpl_wait;
   logic [31:0] cpl_rdata;
   logic        cpl_err;

   int n_vec;
   int n_err;
   int exp_errs;

   apb_if up_if ();
   apb_if dn_if [2] ();

   apb_decoder #(
      .NUM_DST        (2),
      .SEL_MSB        (31),
      .SEL_LSB        (24),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .apbUp    (up_if),
      .apbDn    (dn_if),
      .errCount (err_count),
      .toSticky (to_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Completer models plus per-port monitors.
   for (genvar g = 0; g < 2; g++) begin : g_cpl
      int          acc_cnt;
      int          psel_cyc;
      logic [31:0] last_addr;
      logic [31:0] last_wdata;
      logic        last_write;

      always @(posedge clk) begin
         if (dn_if[g].psel && dn_if[g].penable && !dn_if[g].pready) acc_cnt <= acc_cnt + 1;
         else acc_cnt <= 0;
      end

      assign dn_if[g].pready  = dn_if[g].psel & dn_if[g].penable & ~cpl_hang[g] & (acc_cnt == cpl_wait);
      assign dn_if[g].prdata  = cpl_rdata;
      assign dn_if[g].pslverr = cpl_err;

      always @(negedge clk) begin
         if (rst) begin
            psel_cyc <= 0;
         end else if (dn_if[g].psel) begin
            psel_cyc   <= psel_cyc + 1;
            last_addr  <= dn_if[g].paddr;
            last_wdata <= dn_if[g].pwdata;
            last_write <= dn_if[g].pwrite;
         end
      end
   end

   typedef struct {
      logic [31:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      int          cwait;
      logic [31:0] crdata;
      logic        cerr;
      int          lat;
      logic [31:0] prdata;
      logic        slverr;
      int          dn0;
      int          dn1;
   } vec_t;

   vec_t vec [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic se);
      @(posedge clk); #1;
      up_if.psel    = 1'b1;
      up_if.penable = 1'b0;
      up_if.paddr   = a;
      up_if.pwrite  = w;
      up_if.pwdata  = d;
      lat = -1;
      rd  = '0;
      se  = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (up_if.pready) begin
            lat = c;
            rd  = up_if.prdata;
            se  = up_if.pslverr;
            break;
         end
         @(posedge clk); #1;
         up_if.penable = 1'b1;
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      up_if.psel    = 1'b0;
      up_if.penable = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        se;
      int          d0, d1;

      n_vec = 0; n_err = 0; exp_errs = 0;
      cpl_hang = 2'b00; cpl_wait = 0; cpl_rdata = '0; cpl_err = 1'b0;
      up_if.psel = 1'b0; up_if.penable = 1'b0; up_if.paddr = '0;
      up_if.pwrite = 1'b0; up_if.pwdata = '0;

      vec[0] = '{32'h0100_0010, 1'b0, 32'h0,         0, 32'hCAFE_0001, 1'b0,  3, 32'hCAFE_0001, 1'b0, 2, 0};
      vec[1] = '{32'h0200_0004, 1'b1, 32'h1234_5678, 3, 32'h0,         1'b0,  6, 32'h0,         1'b0, 0, 5};
      vec[2] = '{32'h7F00_0000, 1'b0, 32'h0,         0, 32'hFFFF_FFFF, 1'b0,  1, 32'h0,         1'b1, 0, 0};
      vec[3] = '{32'h0200_0100, 1'b0, 32'h0,         1, 32'h5555_AAAA, 1'b1,  4, 32'h5555_AAAA, 1'b1, 0, 3};
      vec[4] = '{32'h01FF_FFFC, 1'b0, 32'h0,         7, 32'h0BAD_F00D, 1'b0, 10, 32'h0BAD_F00D, 1'b0, 9, 0};
      vec[5] = '{32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 0, 32'h0,         1'b0,  1, 32'h0,         1'b1, 0, 0};
      vec[6] = '{32'h0100_0008, 1'b1, 32'hA5A5_5A5A, 2, 32'h0,         1'b0,  5, 32'h0,         1'b0, 4, 0};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_up_pready",  {31'b0, up_if.pready},    32'h0);
      chk("rst_up_prdata",  up_if.prdata,             32'h0);
      chk("rst_up_pslverr", {31'b0, up_if.pslverr},   32'h0);
      chk("rst_errcount",   {16'b0, err_count},       32'h0);
      chk("rst_tosticky",   {31'b0, to_sticky},       32'h0);
      chk("rst_dn0_psel",   {31'b0, dn_if[0].psel},   32'h0);
      chk("rst_dn1_penable",{31'b0, dn_if[1].penable},32'h0);
      chk("rst_dn0_paddr",  dn_if[0].paddr,           32'h0);

      for (int i = 0; i < 7; i++) begin
         cpl_wait  = vec[i].cwait;
         cpl_rdata = vec[i].crdata;
         cpl_err   = vec[i].cerr;
         d0 = g_cpl[0].psel_cyc;
         d1 = g_cpl[1].psel_cyc;
         xfer(vec[i].paddr, vec[i].pwrite, vec[i].pwdata, lat, rd, se);
         idle();
         if (vec[i].slverr) exp_errs++;
         chk($sformatf("v%0d_latency", i), lat,                       vec[i].lat);
         chk($sformatf("v%0d_prdata", i),  rd,                        vec[i].prdata);
         chk($sformatf("v%0d_pslverr", i), {31'b0, se},               {31'b0, vec[i].slverr});
         chk($sformatf("v%0d_errcount", i),{16'b0, err_count},        exp_errs);
         chk($sformatf("v%0d_dn0_cyc", i), g_cpl[0].psel_cyc - d0,    vec[i].dn0);
         chk($sformatf("v%0d_dn1_cyc", i), g_cpl[1].psel_cyc - d1,    vec[i].dn1);
         if (vec[i].dn0 != 0) begin
            chk($sformatf("v%0d_dn0_addr", i),  g_cpl[0].last_addr,  vec[i].paddr);
            chk($sformatf("v%0d_dn0_wdata", i), g_cpl[0].last_wdata, vec[i].pwdata);
            chk($sformatf("v%0d_dn0_write", i), {31'b0, g_cpl[0].last_write}, {31'b0, vec[i].pwrite});
         end
         if (vec[i].dn1 != 0) begin
            chk($sformatf("v%0d_dn1_addr", i),  g_cpl[1].last_addr,  vec[i].paddr);
            chk($sformatf("v%0d_dn1_wdata", i), g_cpl[1].last_wdata, vec[i].pwdata);
            chk($sformatf("v%0d_dn1_write", i), {31'b0, g_cpl[1].last_write}, {31'b0, vec[i].pwrite});
         end
      end
      chk("expiry_no_sticky", {31'b0, to_sticky}, 32'h0);

      // Timeout on port 1: 8 access cycles, then synthesised error.
      cpl_hang = 2'b10; cpl_wait = 0; cpl_rdata = 32'h1111_1111; cpl_err = 1'b0;
      d1 = g_cpl[1].psel_cyc;
      xfer(32'h0200_0010, 1'b0, 32'h0, lat, rd, se);
      exp_errs++;
      chk("tmo_latency",  lat,               10);
      chk("tmo_prdata",   rd,                32'h0);
      chk("tmo_pslverr",  {31'b0, se},       32'h1);
      chk("tmo_sticky",   {31'b0, to_sticky},32'h1);
      idle();
      @(negedge clk);
      chk("tmo_dn1_psel_c11", {31'b0, dn_if[1].psel}, 32'h0);
      chk("tmo_dn1_cyc",  g_cpl[1].psel_cyc - d1, 9);
      chk("tmo_errcount", {16'b0, err_count}, exp_errs);
      cpl_hang = 2'b00;

      // Back-to-back: unmapped then a hit accepted in the IDLE cycle right after RESP.
      cpl_wait = 0; cpl_rdata = 32'h0000_B2B0; cpl_err = 1'b0;
      xfer(32'h5500_0000, 1'b0, 32'h0, lat, rd, se);
      exp_errs++;
      chk("b2b_a_latency", lat, 1);
      xfer(32'h0100_0020, 1'b0, 32'h0, lat, rd, se);
      chk("b2b_b_latency", lat, 3);
      chk("b2b_b_prdata",  rd,  32'h0000_B2B0);
      idle();
      chk("b2b_errcount", {16'b0, err_count}, exp_errs);
      chk("b2b_sticky",   {31'b0, to_sticky}, 32'h1);

      // Reset while port 0 sits in ACCESS.
      cpl_hang = 2'b01;
      @(posedge clk); #1;
      up_if.psel = 1'b1; up_if.penable = 1'b0;
      up_if.paddr = 32'h0100_0044; up_if.pwrite = 1'b1; up_if.pwdata = 32'h7777_0000;
      @(posedge clk); #1 up_if.penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_rst_dn0_penable", {31'b0, dn_if[0].penable}, 32'h1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      up_if.psel = 1'b0; up_if.penable = 1'b0;
      chk("mid_rst_dn0_psel",    {31'b0, dn_if[0].psel},    32'h0);
      chk("mid_rst_dn0_penable", {31'b0, dn_if[0].penable}, 32'h0);
      chk("mid_rst_dn0_paddr",   dn_if[0].paddr,            32'h0);
      chk("mid_rst_dn0_pwdata",  dn_if[0].pwdata,           32'h0);
      chk("mid_rst_dn0_pwrite",  {31'b0, dn_if[0].pwrite},  32'h0);
      chk("mid_rst_up_pready",   {31'b0, up_if.pready},     32'h0);
      chk("mid_rst_up_prdata",   up_if.prdata,              32'h0);
      chk("mid_rst_up_pslverr",  {31'b0, up_if.pslverr},    32'h0);
      chk("mid_rst_errcount",    {16'b0, err_count},        32'h0);
      chk("mid_rst_sticky",      {31'b0, to_sticky},        32'h0);
      cpl_hang = 2'b00;
      exp_errs = 0;

      cpl_wait = 0; cpl_rdata = 32'h600D_0001; cpl_err = 1'b0;
      xfer(32'h0200_0000, 1'b0, 32'h0, lat, rd, se);
      idle();
      chk("post_rst_latency", lat,          3);
      chk("post_rst_prdata",  rd,           32'h600D_0001);
      chk("post_rst_pslverr", {31'b0, se},  32'h0);

      // Saturation: preload just below the ceiling, then two more errors.
      @(negedge clk);
      force dut.err_cnt_q = 16'hFFFE;
      #1 release dut.err_cnt_q;
      xfer(32'h0300_0000, 1'b0, 32'h0, lat, rd, se);
      idle();
      chk("sat_reach_ffff", {16'b0, err_count}, 32'h0000_FFFF);
      xfer(32'h0400_0000, 1'b0, 32'h0, lat, rd, se);
      idle();
      chk("sat_hold_ffff",  {16'b0, err_count}, 32'h0000_FFFF);
      chk("sat_pslverr",    {31'b0, se},        32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
